spi_qsys_nios2_qsys_0_oci_dct_drain: RTL and testbench

Consumer end of the OCI debug-capture-trace (DCT) buffer interface. Accepts a packed snapshot of up to 15 two-bit trace entries (30-bit buffer plus 4-bit count) over a valid/ready handshake. Serialises the entries one per cycle onto an entry stream for the trace/test-bench side. Honours the test-ending handshake by draining the in-flight snapshot, then reporting test end.

---
 rtl/spi_qsys_nios2_qsys_0_oci_dct_drain.sv | 82 ++++++++
 tb/tb_spi_qsys_nios2_qsys_0_oci_dct_drain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_qsys_nios2_qsys_0_oci_dct_drain.sv
// spi_qsys_nios2_qsys_0_oci_dct_drain: serialise DCT trace snapshots into a one-entry-per-cycle stream
module spi_qsys_nios2_qsys_0_oci_dct_drain #(
    parameter int ENTRY_W = 2,
    parameter int DEPTH   = 15,
    parameter int CNT_W   = 4,
    parameter int SENT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dct_load_valid,
    output logic                     dct_load_ready,
    input  logic [ENTRY_W*DEPTH-1:0] dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    output logic                     entry_valid,
    input  logic                     entry_ready,
    output logic [ENTRY_W-1:0]       entry_data,
    output logic                     entry_last,
    input  logic                     test_ending,
    output logic                     test_has_ended,
    output logic                     busy,
    output logic [SENT_W-1:0]        entries_sent
);

    typedef enum logic [1:0] {IDLE, SHIFT, ENDED} state_t;

    state_t                     state;
    logic [ENTRY_W*DEPTH-1:0]   shreg;
    logic [CNT_W-1:0]           remaining;

    assign dct_load_ready = (state == IDLE) & ~test_ending & ~reset;
    assign entry_data     = shreg[ENTRY_W-1:0];

    // Snapshot capture, entry shifting and end-of-test sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            remaining      <= '0;
            entry_valid    <= 1'b0;
            entry_last     <= 1'b0;
            test_has_ended <= 1'b0;
            busy           <= 1'b0;
            entries_sent   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (test_ending) begin
                        state          <= ENDED;
                        test_has_ended <= 1'b1;
                    end else if (dct_load_valid && dct_count != '0) begin
                        state       <= SHIFT;
                        shreg       <= dct_buffer;
                        remaining   <= dct_count;
                        entry_valid <= 1'b1;
                        entry_last  <= (dct_count == CNT_W'(1));
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (entry_ready) begin
                        shreg        <= shreg >> ENTRY_W;
                        remaining    <= remaining - CNT_W'(1);
                        entries_sent <= entries_sent + SENT_W'(1);
                        entry_last   <= (remaining == CNT_W'(2));
                        if (remaining == CNT_W'(1)) begin
                            state          <= test_ending ? ENDED : IDLE;
                            test_has_ended <= test_ending;
                            entry_valid    <= 1'b0;
                            entry_last     <= 1'b0;
                            busy           <= 1'b0;
                        end
                    end
                end
                default: begin
                    state          <= ENDED;
                    test_has_ended <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_qsys_nios2_qsys_0_oci_dct_drain.sv
// tb_spi_qsys_nios2_qsys_0_oci_dct_drain: directed table-driven bench for the DCT drain
module tb_spi_qsys_nios2_qsys_0_oci_dct_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        dct_load_valid;
    logic        dct_load_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        entry_valid;
    logic        entry_ready;
    logic [1:0]  entry_data;
    logic        entry_last;
    logic        test_ending;
    logic        test_has_ended;
    logic        busy;
    logic [15:0] entries_sent;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_sent = '0;

    typedef struct {
        logic [29:0] b;
        logic [3:0]  c;
        bit          tog;
        logic [15:0] sent_after;
    } vec_t;

    vec_t vecs[5];

    spi_qsys_nios2_qsys_0_oci_dct_drain dut (
        .clk            (clk),
        .reset          (reset),
        .dct_load_valid (dct_load_valid),
        .dct_load_ready (dct_load_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .entry_valid    (entry_valid),
        .entry_ready    (entry_ready),
        .entry_data     (entry_data),
        .entry_last     (entry_last),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .busy           (busy),
        .entries_sent   (entries_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Offer one snapshot and drain it, checking every entry against the packed buffer.
    task automatic run_snap(input logic [29:0] b, input logic [3:0] c, input bit tog);
        int i;
        int cyc;
        logic [29:0] sh;
        chk("load_ready_before", {31'd0, dct_load_ready}, 1);
        dct_load_valid = 1'b1;
        dct_buffer     = b;
        dct_count      = c;
        entry_ready    = 1'b0;
        step;
        dct_load_valid = 1'b0;
        i   = 0;
        cyc = 0;
        while (i < int'(c) && cyc < 64) begin
            entry_ready = tog ? (cyc % 2 == 0) : 1'b1;
            sh = b >> (2 * i);
            chk("entry_valid", {31'd0, entry_valid}, 1);
            chk("entry_data", {30'd0, entry_data}, {30'd0, sh[1:0]});
            chk("entry_last", {31'd0, entry_last}, {31'd0, i == int'(c) - 1});
            chk("busy", {31'd0, busy}, 1);
            step;
            if (entry_ready) i++;
            cyc++;
        end
        if (i < int'(c)) chk("snap_timeout", i, {28'd0, c});
        entry_ready = 1'b0;
        exp_sent    = exp_sent + 16'(c);
        chk("entry_valid_after", {31'd0, entry_valid}, 0);
        chk("busy_after", {31'd0, busy}, 0);
        chk("sent_after", {16'd0, entries_sent}, {16'd0, exp_sent});
        chk("load_ready_after", {31'd0, dct_load_ready}, 1);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{30'h0000_001B, 4'd3,  1'b0, 16'd3};
        vecs[1] = '{30'h2AAA_AAAA, 4'd15, 1'b1, 16'd18};
        vecs[2] = '{30'h0000_0000, 4'd0,  1'b0, 16'd18};
        vecs[3] = '{30'h3FFF_FFFF, 4'd1,  1'b0, 16'd19};
        vecs[4] = '{30'h1234_5678, 4'd7,  1'b1, 16'd26};

        reset = 1'b1; dct_load_valid = 1'b0; dct_buffer = '0; dct_count = '0;
        entry_ready = 1'b0; test_ending = 1'b0;
        #1;
        chk("rst_load_ready", {31'd0, dct_load_ready}, 0);
        step; step;
        chk("rst_entry_valid", {31'd0, entry_valid}, 0);
        chk("rst_entry_data", {30'd0, entry_data}, 0);
        chk("rst_entry_last", {31'd0, entry_last}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ended", {31'd0, test_has_ended}, 0);
        chk("rst_sent", {16'd0, entries_sent}, 0);
        reset = 1'b0;
        step;
        chk("post_rst_load_ready", {31'd0, dct_load_ready}, 1);

        for (int k = 0; k < 5; k++) begin
            run_snap(vecs[k].b, vecs[k].c, vecs[k].tog);
            chk("table_sent", {16'd0, entries_sent}, {16'd0, vecs[k].sent_after});
        end

        // Run full snapshots back to back until the counter reaches 65520 (a snapshot boundary).
        reset = 1'b1; step; reset = 1'b0; step;
        dct_load_valid = 1'b1; dct_buffer = 30'h1555_5555; dct_count = 4'd15; entry_ready = 1'b1;
        cyc = 0;
        while (entries_sent != 16'd65520 && cyc < 80000) begin
            step;
            cyc++;
        end
        dct_load_valid = 1'b0; entry_ready = 1'b0;
        chk("bulk_sent", {16'd0, entries_sent}, 32'd65520);
        exp_sent = 16'd65520;
        step;
        run_snap(30'h0000_0E4E, 4'd14, 1'b0);
        chk("sent_fffe", {16'd0, entries_sent}, 32'hFFFE);
        run_snap(30'h0000_0039, 4'd3, 1'b0);
        chk("sent_wrap", {16'd0, entries_sent}, 32'h0001);

        // Asynchronous reset between edges in the middle of a snapshot.
        dct_load_valid = 1'b1; dct_buffer = 30'h0000_03FF; dct_count = 4'd5; entry_ready = 1'b1;
        step;
        dct_load_valid = 1'b0;
        step; step;
        chk("mid_valid_pre", {31'd0, entry_valid}, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_entry_valid", {31'd0, entry_valid}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        chk("async_sent", {16'd0, entries_sent}, 0);
        chk("async_load_ready", {31'd0, dct_load_ready}, 0);
        entry_ready = 1'b0;
        step;
        reset = 1'b0;
        exp_sent = '0;
        step;
        run_snap(30'h0000_0002, 4'd1, 1'b0);

        // test_ending raised after two of five entries: the rest still drains.
        dct_load_valid = 1'b1; dct_buffer = 30'h0000_00E4; dct_count = 4'd5; entry_ready = 1'b1;
        step;
        dct_load_valid = 1'b0;
        chk("te_d0", {30'd0, entry_data}, 0);
        step;
        chk("te_d1", {30'd0, entry_data}, 1);
        step;
        test_ending = 1'b1;
        chk("te_d2", {30'd0, entry_data}, 2);
        chk("te_valid2", {31'd0, entry_valid}, 1);
        step;
        chk("te_d3", {30'd0, entry_data}, 3);
        step;
        chk("te_d4", {30'd0, entry_data}, 0);
        chk("te_last4", {31'd0, entry_last}, 1);
        chk("te_not_ended_yet", {31'd0, test_has_ended}, 0);
        step;
        chk("te_ended", {31'd0, test_has_ended}, 1);
        chk("te_valid_off", {31'd0, entry_valid}, 0);
        chk("te_sent", {16'd0, entries_sent}, 32'd6);
        test_ending = 1'b0; dct_load_valid = 1'b1; dct_count = 4'd3;
        chk("te_load_refused", {31'd0, dct_load_ready}, 0);
        step; step;
        chk("te_sticky", {31'd0, test_has_ended}, 1);
        chk("te_no_entry", {31'd0, entry_valid}, 0);
        chk("te_no_busy", {31'd0, busy}, 0);
        dct_load_valid = 1'b0;

        // test_ending and a load offer in the same idle cycle: the load is refused.
        reset = 1'b1; step; reset = 1'b0; step;
        dct_load_valid = 1'b1; test_ending = 1'b1; dct_count = 4'd2;
        #1;
        chk("same_cycle_ready", {31'd0, dct_load_ready}, 0);
        step;
        chk("same_cycle_ended", {31'd0, test_has_ended}, 1);
        chk("same_cycle_valid", {31'd0, entry_valid}, 0);
        dct_load_valid = 1'b0; test_ending = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
